sr_cpu_mc: RTL and testbench

Multicycle successor of the single-cycle schoolRISCV core: a two-state fetch/execute RV32I-subset CPU whose instruction memory has a request/acknowledge handshake with any number of wait states. Adds a parametrised reset vector and memory address width, plus JAL, SLLI, BLTU and ANDI, an illegal-instruction flag and a retire strobe. It sits at the top of the CPU hierarchy between the instruction memory (ROM or a bus bridge) and the board-level debug display logic.

---
 rtl/sr_cpu_mc_if.sv | 11 +
 rtl/sr_cpu_mc.sv | 97 +++++++++
 tb/tb_sr_cpu_mc.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/sr_cpu_mc_if.sv
// sr_cpu_mc_if: instruction-memory request/acknowledge bus between the CPU and its ROM or bus bridge
interface sr_cpu_mc_if #(
  parameter int IM_ADDR_W = 30
);
  logic                 imReq;
  logic [IM_ADDR_W-1:0] imAddr;
  logic                 imAck;
  logic [31:0]          imData;
  modport master (output imReq, imAddr, input imAck, imData);
  modport slave  (input imReq, imAddr, output imAck, imData);
endinterface

// File: rtl/sr_cpu_mc.sv
// sr_cpu_mc: two-state fetch/execute RV32I-subset CPU with a handshaked instruction memory
module sr_cpu_mc #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IM_ADDR_W = 30
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4:0]         regAddr,
  output logic [31:0]        regData,
  sr_cpu_mc_if.master        im,
  output logic               retire,
  output logic               illegal
);
  typedef enum logic {S_FETCH, S_EXEC} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_pc, r_instr;
  logic [31:0] r_rf [32];
  logic [6:0]  w_op, w_f7;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3;
  logic [31:0] w_a, w_b, w_imm_i, w_imm_b, w_imm_j, w_imm_u, w_pc4, w_pc_next, w_wd;
  logic        w_legal, w_we, w_taken, w_jal, w_rf_we;
  assign w_op    = r_instr[6:0];
  assign w_rd    = r_instr[11:7];
  assign w_f3    = r_instr[14:12];
  assign w_rs1   = r_instr[19:15];
  assign w_rs2   = r_instr[24:20];
  assign w_f7    = r_instr[31:25];
  assign w_imm_i = {{20{r_instr[31]}}, r_instr[31:20]};
  assign w_imm_b = {{19{r_instr[31]}}, r_instr[31], r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0};
  assign w_imm_j = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12], r_instr[20], r_instr[30:21], 1'b0};
  assign w_imm_u = {r_instr[31:12], 12'b0};
  assign w_a     = (w_rs1 == 5'd0) ? 32'd0 : r_rf[w_rs1];
  assign w_b     = (w_rs2 == 5'd0) ? 32'd0 : r_rf[w_rs2];
  assign w_pc4   = r_pc + 32'd4;
  // bit 1 of a branch/jump target is kept in pc; the word address simply drops it
  assign w_pc_next = w_jal ? r_pc + w_imm_j : w_taken ? r_pc + w_imm_b : w_pc4;
  assign w_rf_we   = (r_state == S_EXEC) && w_we && (w_rd != 5'd0);
  assign im.imAddr = r_pc[IM_ADDR_W+1:2];
  assign regData   = (regAddr == 5'd0) ? r_pc : r_rf[regAddr];
  // decode and execute: anything not matched below stays illegal with no write and pc+4
  always_comb begin
    w_legal = 1'b0;
    w_we    = 1'b0;
    w_wd    = 32'd0;
    w_taken = 1'b0;
    w_jal   = 1'b0;
    case (w_op)
      7'b0110011: case ({w_f7, w_f3})
        10'b0000000_000: begin w_legal = 1'b1; w_we = 1'b1; w_wd = w_a + w_b; end
        10'b0100000_000: begin w_legal = 1'b1; w_we = 1'b1; w_wd = w_a - w_b; end
        10'b0000000_110: begin w_legal = 1'b1; w_we = 1'b1; w_wd = w_a | w_b; end
        10'b0000000_011: begin w_legal = 1'b1; w_we = 1'b1; w_wd = {31'd0, w_a < w_b}; end
        default: ;
      endcase
      7'b0010011: case (w_f3)
        3'b000: begin w_legal = 1'b1; w_we = 1'b1; w_wd = w_a + w_imm_i; end
        3'b111: begin w_legal = 1'b1; w_we = 1'b1; w_wd = w_a & w_imm_i; end
        3'b001: begin w_legal = (w_f7 == 7'd0); w_we = w_legal; w_wd = w_a << w_rs2; end
        3'b101: begin w_legal = (w_f7 == 7'd0); w_we = w_legal; w_wd = w_a >> w_rs2; end
        default: ;
      endcase
      7'b0110111: begin w_legal = 1'b1; w_we = 1'b1; w_wd = w_imm_u; end
      7'b1100011: case (w_f3)
        3'b000: begin w_legal = 1'b1; w_taken = (w_a == w_b); end
        3'b001: begin w_legal = 1'b1; w_taken = (w_a != w_b); end
        3'b110: begin w_legal = 1'b1; w_taken = (w_a < w_b); end
        default: ;
      endcase
      7'b1101111: begin w_legal = 1'b1; w_we = 1'b1; w_wd = w_pc4; w_jal = 1'b1; end
      default: ;
    endcase
  end
  // state register: reset always restarts with a fetch
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  // next state: leave FETCH only on an acknowledged request, EXEC always lasts one cycle
  always_comb
    w_next = (r_state == S_FETCH) ? (im.imAck ? S_EXEC : S_FETCH) : S_FETCH;
  // outputs: request while fetching, retire/illegal strobes only while executing
  always_comb begin
    im.imReq = (r_state == S_FETCH);
    retire   = (r_state == S_EXEC);
    illegal  = (r_state == S_EXEC) && !w_legal;
  end
  // pc and instruction latch; the reset value of instr is a NOP
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_instr <= 32'h0000_0013;
    end else if (r_state == S_EXEC) r_pc <= w_pc_next;
    else if (im.imAck) r_instr <= im.imData;
  // register file write; contents deliberately survive reset
  always_ff @(posedge clk)
    if (w_rf_we) r_rf[w_rd] <= w_wd;
endmodule

// File: tb/tb_sr_cpu_mc.sv
// tb_sr_cpu_mc: directed program checks for sr_cpu_mc with a stalling instruction memory
module tb_sr_cpu_mc;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst2_n = 1'b0;
  logic [4:0]  regAddr = 5'd0, regAddr2 = 5'd0;
  logic [31:0] regData, regData2;
  logic        retire, illegal, retire2, illegal2;
  logic        force_ack = 1'b1, ack2 = 1'b0;
  logic [31:0] data2 = 32'h0000_0013;
  logic [31:0] mem [256];
  int          max_stall = 0, wcnt = 0;
  int          n_chk = 0, n_err = 0, n_ret = 0, n_ill = 0, s_ret, s_ill;
  logic        p_wait = 1'b0, p_ret = 1'b0;
  logic [29:0] p_addr = '0;
  sr_cpu_mc_if #(.IM_ADDR_W(30)) im ();
  sr_cpu_mc_if #(.IM_ADDR_W(30)) im2 ();
  sr_cpu_mc #(.RESET_PC(32'h0), .IM_ADDR_W(30)) u_dut (
    .clk(clk), .rst_n(rst_n), .regAddr(regAddr), .regData(regData),
    .im(im.master), .retire(retire), .illegal(illegal));
  sr_cpu_mc #(.RESET_PC(32'h100), .IM_ADDR_W(30)) u_dut2 (
    .clk(clk), .rst_n(rst2_n), .regAddr(regAddr2), .regData(regData2),
    .im(im2.master), .retire(retire2), .illegal(illegal2));
  always #5 clk = ~clk;
  assign im.imAck   = force_ack || (im.imReq && wcnt == 0);
  assign im.imData  = mem[im.imAddr[7:0]];
  assign im2.imAck  = ack2;
  assign im2.imData = data2;
  always @(posedge clk)
    if (im.imReq && !force_ack) wcnt <= im.imAck ? int'($urandom_range(max_stall, 0)) : wcnt - 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (p_wait) chk("addr_hold", {2'b0, im.imAddr}, {2'b0, p_addr});
      if (retire) chk("ret_gap", {31'd0, p_ret}, 32'd0);
      if (illegal) chk("ill_ret", {31'd0, retire}, 32'd1);
      if (retire) n_ret <= n_ret + 1;
      if (illegal) n_ill <= n_ill + 1;
    end
    p_wait <= rst_n && im.imReq && !im.imAck;
    p_addr <= im.imAddr;
    p_ret  <= retire;
  end
  task automatic clear_mem();
    foreach (mem[i]) mem[i] = 32'h0000_006F;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic wait_pc(input logic [31:0] t);
    regAddr = 5'd0;
    for (int i = 0; i < 400 && regData !== t; i++) @(negedge clk);
    chk("pc_reach", regData, t);
  endtask
  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    regAddr = a;
    #1 chk(tag, regData, exp);
  endtask
  task automatic rd2(input string tag, input logic [4:0] a, input logic [31:0] exp);
    regAddr2 = a;
    #1 chk(tag, regData2, exp);
  endtask
  task automatic load_arith();
    clear_mem();
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0070_0113;
    mem[2] = 32'h0020_81B3;
    mem[3] = 32'h4020_8233;
  endtask
  initial begin
    load_arith();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, im.imReq}, 32'd1);
    chk("rst_ret", {31'd0, retire}, 32'd0);
    chk("rst_ill", {31'd0, illegal}, 32'd0);
    chk("rst_addr", {2'b0, im.imAddr}, 32'd0);
    rd("rst_pc", 5'd0, 32'd0);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("ret_pat", {31'd0, retire}, i % 2);
    end
    rd("zw_pc", 5'd0, 32'h10);
    rd("zw_x1", 5'd1, 32'd5);
    rd("zw_x2", 5'd2, 32'd7);
    rd("zw_x3", 5'd3, 32'd12);
    rd("zw_x4", 5'd4, 32'hFFFF_FFFE);
    force_ack = 1'b0;
    max_stall = 5;
    load_arith();
    do_reset();
    s_ret = n_ret;
    wait_pc(32'h10);
    chk("st_rets", n_ret - s_ret, 32'd4);
    rd("st_x3", 5'd3, 32'd12);
    rd("st_x4", 5'd4, 32'hFFFF_FFFE);
    clear_mem();
    mem[0]  = 32'h0030_0093;
    mem[1]  = 32'h0050_0113;
    mem[2]  = 32'h0020_E463;
    mem[3]  = 32'h0630_0093;
    mem[4]  = 32'h0020_8463;
    mem[5]  = 32'h00B0_0393;
    mem[6]  = 32'h0020_9463;
    mem[7]  = 32'h0630_0113;
    mem[8]  = 32'h0200_006F;
    mem[16] = 32'hFF1F_F2EF;
    mem[12] = 32'h0000_006F;
    max_stall = 1;
    do_reset();
    s_ret = n_ret;
    wait_pc(32'h30);
    chk("br_rets", n_ret - s_ret, 32'd8);
    rd("br_x1", 5'd1, 32'd3);
    rd("br_x2", 5'd2, 32'd5);
    rd("br_x7", 5'd7, 32'd11);
    rd("jal_x5", 5'd5, 32'h44);
    clear_mem();
    mem[0]  = 32'h8000_00B7;
    mem[1]  = 32'h0010_8093;
    mem[2]  = 32'h0040_9113;
    mem[3]  = 32'h01F0_D193;
    mem[4]  = 32'hFFF0_F213;
    mem[5]  = 32'hABCD_E2B7;
    mem[6]  = 32'h0090_0013;
    mem[7]  = 32'h0010_6433;
    mem[8]  = 32'hFFFF_FFFF;
    mem[9]  = 32'h0050_E333;
    mem[10] = 32'h0011_33B3;
    mem[11] = 32'h0240_9113;
    max_stall = 2;
    do_reset();
    s_ret = n_ret;
    s_ill = n_ill;
    wait_pc(32'h30);
    chk("sh_rets", n_ret - s_ret, 32'd12);
    chk("sh_ills", n_ill - s_ill, 32'd2);
    rd("lui_x1", 5'd1, 32'h8000_0001);
    rd("slli_x2", 5'd2, 32'h0000_0010);
    rd("srli_x3", 5'd3, 32'd1);
    rd("andi_x4", 5'd4, 32'h8000_0001);
    rd("lui_x5", 5'd5, 32'hABCD_E000);
    rd("x0_or", 5'd8, 32'h8000_0001);
    rd("or_x6", 5'd6, 32'hABCD_E001);
    rd("sltu_x7", 5'd7, 32'd1);
    @(negedge clk);
    rst2_n = 1'b1;
    data2 = 32'h0010_0093;
    ack2 = 1'b1;
    @(negedge clk);
    chk("d2_ret", {31'd0, retire2}, 32'd1);
    ack2 = 1'b0;
    @(negedge clk);
    chk("d2_req", {31'd0, im2.imReq}, 32'd1);
    chk("d2_addr", {2'b0, im2.imAddr}, 32'h41);
    @(negedge clk);
    rst2_n = 1'b0;
    #1 chk("d2_rreq", {31'd0, im2.imReq}, 32'd1);
    chk("d2_raddr", {2'b0, im2.imAddr}, 32'h40);
    chk("d2_rret", {31'd0, retire2}, 32'd0);
    rd2("d2_rpc", 5'd0, 32'h100);
    @(negedge clk);
    rst2_n = 1'b1;
    @(negedge clk);
    chk("d2_req2", {31'd0, im2.imReq}, 32'd1);
    chk("d2_addr2", {2'b0, im2.imAddr}, 32'h40);
    chk("d2_noret", {31'd0, retire2}, 32'd0);
    rd2("d2_x1", 5'd1, 32'd1);
    data2 = 32'h0020_0093;
    ack2 = 1'b1;
    @(negedge clk);
    chk("d2_exec", {31'd0, retire2}, 32'd1);
    rst2_n = 1'b0;
    ack2 = 1'b0;
    #1 chk("d2_abort", {31'd0, retire2}, 32'd0);
    @(negedge clk);
    rd2("d2_x1_kept", 5'd1, 32'd1);
    rd2("d2_pc_kept", 5'd0, 32'h100);
    rst2_n = 1'b1;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
  initial begin
    #400000;
    $display("FAIL global_timeout got %0d expected 0", 1);
    $fatal(1);
  end
endmodule
